// File: rtl/alu_seq_pkg.sv
// Shared types and opcode helpers for the ALU instruction sequencer.
//   state_e      : sequencer states (fetch T0-T2, execute T3-T6, Done)
//   opcode_t     : 5-bit opcode field from ir[31:27]
//   is_unary     : NEG/NOT, which take their single operand from rb
//   is_two_word  : MUL/DIV, which write LO then HI instead of a register
//   is_legal     : opcodes this sequencer knows how to run
package alu_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StDone
  } state_e;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OpAdd  = 5'b00011;
  localparam opcode_t OpSub  = 5'b00100;
  localparam opcode_t OpAnd  = 5'b00101;
  localparam opcode_t OpOr   = 5'b00110;
  localparam opcode_t OpRor  = 5'b00111;
  localparam opcode_t OpRol  = 5'b01000;
  localparam opcode_t OpShr  = 5'b01001;
  localparam opcode_t OpShra = 5'b01010;
  localparam opcode_t OpShl  = 5'b01011;
  localparam opcode_t OpMul  = 5'b01111;
  localparam opcode_t OpDiv  = 5'b10000;
  localparam opcode_t OpNeg  = 5'b10001;
  localparam opcode_t OpNot  = 5'b10010;

  function automatic logic is_unary(opcode_t op);
    return (op == OpNeg) || (op == OpNot);
  endfunction

  function automatic logic is_two_word(opcode_t op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

  function automatic logic is_legal(opcode_t op);
    logic ok;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl,
      OpMul, OpDiv, OpNeg, OpNot: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_reg_select_decoder.sv
// Binary register index to one-hot select.
//   idx_i : register index
//   en_i  : when low the output is all zeros
//   sel_o : one-hot select; indices >= NumRegs select nothing
module reg_select_decoder #(
  parameter int unsigned NumRegs = 16,
  parameter int unsigned IdxW    = $clog2(NumRegs)
) (
  input  logic [IdxW-1:0]    idx_i,
  input  logic               en_i,
  output logic [NumRegs-1:0] sel_o
);

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (en_i && (idx_i == IdxW'(i))) begin
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control sequencer that runs one R-format ALU instruction through the datapath:
// fetch (T0-T2) then execute (T3-T5, plus T6 for MUL/DIV HI/LO writes).
//   clk_i, clr_ni       : clock, asynchronous active-low reset
//   start_i             : begin one instruction (sampled only in Idle)
//   ir_i                : IR contents; opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
//   pc_out_o .. y_in_o  : fetch/operand datapath controls
//   zhi_in_o .. lo_in_o : Z/HI/LO controls
//   reg_out_sel_o       : one-hot register bus drive
//   reg_in_sel_o        : one-hot register load
//   operation_o         : ALU operation, non-zero only in T4
//   busy_o              : high from T0 through Done
//   done_o, illegal_o   : end-of-instruction pulse, and its unsupported-opcode flag
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NumRegs = 16,
  parameter int unsigned MemWait = 0,
  parameter int unsigned OpW     = 5
) (
  input  logic               clk_i,
  input  logic               clr_ni,
  input  logic               start_i,
  input  logic [31:0]        ir_i,
  output logic               pc_out_o,
  output logic               mar_in_o,
  output logic               inc_pc_o,
  output logic               pc_in_o,
  output logic               read_o,
  output logic               mdr_in_o,
  output logic               mdr_out_o,
  output logic               ir_in_o,
  output logic               y_in_o,
  output logic               zhi_in_o,
  output logic               zlo_in_o,
  output logic               zlow_out_o,
  output logic               zhigh_out_o,
  output logic               hi_in_o,
  output logic               lo_in_o,
  output logic [NumRegs-1:0] reg_out_sel_o,
  output logic [NumRegs-1:0] reg_in_sel_o,
  output logic [OpW-1:0]     operation_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               illegal_o
);

  localparam int unsigned RW = $clog2(NumRegs);

  state_e          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  opcode_t         op_q, op_d;
  logic [RW-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  // Register fields are the low RW bits of each 4-bit IR field.
  opcode_t       ir_op;
  logic [RW-1:0] ir_ra, ir_rb, ir_rc;
  logic          unused_ir;
  assign ir_op     = ir_i[31:27];
  assign ir_ra     = ir_i[23 +: RW];
  assign ir_rb     = ir_i[19 +: RW];
  assign ir_rc     = ir_i[15 +: RW];
  assign unused_ir = ^ir_i;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q <= StIdle;
      wait_q  <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;  // counter is only live while in T1
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    case (state_q)
      StIdle: if (start_i) state_d = StT0;
      StT0:   state_d = StT1;
      StT1: begin
        if (wait_q == 4'(MemWait)) begin
          state_d = StT2;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StT2:   state_d = StT3;
      StT3: begin
        op_d    = ir_op;
        ra_d    = ir_ra;
        rb_d    = ir_rb;
        rc_d    = ir_rc;
        state_d = is_legal(ir_op) ? StT4 : StDone;
      end
      StT4:   state_d = StT5;
      StT5:   state_d = is_two_word(op_q) ? StT6 : StDone;
      StT6:   state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the state register and the fields latched in T3; T3 itself
  // still reads the live IR because the latch happens at the end of that cycle.
  logic          out_en, in_en;
  logic [RW-1:0] out_idx;

  always_comb begin
    pc_out_o    = 1'b0;
    mar_in_o    = 1'b0;
    inc_pc_o    = 1'b0;
    pc_in_o     = 1'b0;
    read_o      = 1'b0;
    mdr_in_o    = 1'b0;
    mdr_out_o   = 1'b0;
    ir_in_o     = 1'b0;
    y_in_o      = 1'b0;
    zhi_in_o    = 1'b0;
    zlo_in_o    = 1'b0;
    zlow_out_o  = 1'b0;
    zhigh_out_o = 1'b0;
    hi_in_o     = 1'b0;
    lo_in_o     = 1'b0;
    operation_o = '0;
    done_o      = 1'b0;
    illegal_o   = 1'b0;
    out_en      = 1'b0;
    out_idx     = '0;
    in_en       = 1'b0;
    case (state_q)
      StT0: begin
        pc_out_o = 1'b1;
        mar_in_o = 1'b1;
        inc_pc_o = 1'b1;
        zhi_in_o = 1'b1;
        zlo_in_o = 1'b1;
      end
      StT1: begin
        zlow_out_o = 1'b1;
        pc_in_o    = (wait_q == 4'd0);  // reload PC once, not every wait cycle
        read_o     = 1'b1;
        mdr_in_o   = 1'b1;
      end
      StT2: begin
        mdr_out_o = 1'b1;
        ir_in_o   = 1'b1;
      end
      StT3: begin
        if (is_legal(ir_op)) begin
          out_en  = 1'b1;
          out_idx = ir_rb;
          y_in_o  = 1'b1;
        end
      end
      StT4: begin
        out_en      = 1'b1;
        out_idx     = is_unary(op_q) ? rb_q : rc_q;
        operation_o = OpW'(op_q);
        zhi_in_o    = 1'b1;
        zlo_in_o    = 1'b1;
      end
      StT5: begin
        zlow_out_o = 1'b1;
        if (is_two_word(op_q)) begin
          lo_in_o = 1'b1;
        end else begin
          in_en = 1'b1;
        end
      end
      StT6: begin
        zhigh_out_o = 1'b1;
        hi_in_o     = 1'b1;
      end
      StDone: begin
        done_o    = 1'b1;
        illegal_o = !is_legal(op_q);
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != StIdle);

  reg_select_decoder #(
    .NumRegs (NumRegs),
    .IdxW    (RW)
  ) u_out_dec (
    .idx_i (out_idx),
    .en_i  (out_en),
    .sel_o (reg_out_sel_o)
  );

  reg_select_decoder #(
    .NumRegs (NumRegs),
    .IdxW    (RW)
  ) u_in_dec (
    .idx_i (ra_q),
    .en_i  (in_en),
    .sel_o (reg_in_sel_o)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic        zhi_in, zlo_in, zlow_out, zhigh_out, hi_in, lo_in, busy, done, illegal;
    logic [4:0]  op;
    logic [15:0] rout, rin;
  } ctl_t;

  typedef ctl_t sched_t[$];

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  ctl_t        obs [2];

  always #5 clk = ~clk;

  // Two copies: no memory wait states, and two wait states.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic        zhi_in, zlo_in, zlow_out, zhigh_out, hi_in, lo_in, busy, done, illegal;
    logic [4:0]  op;
    logic [15:0] rout, rin;
    alu_instr_sequencer #(
      .NumRegs (16),
      .MemWait (2 * g),
      .OpW     (5)
    ) u_dut (
      .clk_i         (clk),
      .clr_ni        (clr_n),
      .start_i       (start),
      .ir_i          (ir),
      .pc_out_o      (pc_out),
      .mar_in_o      (mar_in),
      .inc_pc_o      (inc_pc),
      .pc_in_o       (pc_in),
      .read_o        (read),
      .mdr_in_o      (mdr_in),
      .mdr_out_o     (mdr_out),
      .ir_in_o       (ir_in),
      .y_in_o        (y_in),
      .zhi_in_o      (zhi_in),
      .zlo_in_o      (zlo_in),
      .zlow_out_o    (zlow_out),
      .zhigh_out_o   (zhigh_out),
      .hi_in_o       (hi_in),
      .lo_in_o       (lo_in),
      .reg_out_sel_o (rout),
      .reg_in_sel_o  (rin),
      .operation_o   (op),
      .busy_o        (busy),
      .done_o        (done),
      .illegal_o     (illegal)
    );
    assign obs[g] = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                     zhi_in, zlo_in, zlow_out, zhigh_out, hi_in, lo_in, busy, done, illegal,
                     op, rout, rin};
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_at [2];
  bit   ill_seen;
  ctl_t snap [16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Reference schedule: the control word expected in each cycle after start is accepted.
  function automatic sched_t build(input logic [31:0] instr, input int mw);
    sched_t     q;
    ctl_t       c;
    logic [4:0] opc = instr[31:27];
    int         ra = int'(instr[26:23]);
    int         rb = int'(instr[22:19]);
    int         rc = int'(instr[18:15]);
    bit legal = opc inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                            5'd15, 5'd16, 5'd17, 5'd18};
    bit two   = opc inside {5'd15, 5'd16};
    bit unary = opc inside {5'd17, 5'd18};
    c = '0; c.busy = 1; c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.zhi_in = 1; c.zlo_in = 1;
    q.push_back(c);
    for (int i = 0; i <= mw; i++) begin
      c = '0; c.busy = 1; c.zlow_out = 1; c.read = 1; c.mdr_in = 1; c.pc_in = (i == 0);
      q.push_back(c);
    end
    c = '0; c.busy = 1; c.mdr_out = 1; c.ir_in = 1;
    q.push_back(c);
    if (legal) begin
      c = '0; c.busy = 1; c.rout = 16'd1 << rb; c.y_in = 1;
      q.push_back(c);
      c = '0; c.busy = 1; c.rout = 16'd1 << (unary ? rb : rc); c.op = opc;
      c.zhi_in = 1; c.zlo_in = 1;
      q.push_back(c);
      c = '0; c.busy = 1; c.zlow_out = 1;
      if (two) c.lo_in = 1; else c.rin = 16'd1 << ra;
      q.push_back(c);
      if (two) begin
        c = '0; c.busy = 1; c.zhigh_out = 1; c.hi_in = 1;
        q.push_back(c);
      end
    end else begin
      c = '0; c.busy = 1;
      q.push_back(c);
    end
    c = '0; c.busy = 1; c.done = 1; c.illegal = !legal;
    q.push_back(c);
    return q;
  endfunction

  // Start one instruction and check every cycle until both copies are back in Idle.
  // pulse_idx >= 0 raises start again during that cycle (must be ignored).
  task automatic run_instr(input logic [31:0] instr, input int pulse_idx);
    sched_t s [2];
    ctl_t   e;
    int     n_max;
    s[0] = build(instr, 0);
    s[1] = build(instr, 2);
    n_max = s[1].size() + 2;
    done_at[0] = -1;
    done_at[1] = -1;
    ill_seen   = 0;
    @(negedge clk);
    ir    = instr;
    start = 1'b1;
    for (int n = 0; n < n_max; n++) begin
      @(negedge clk);
      start = (n == pulse_idx);
      for (int g = 0; g < 2; g++) begin
        e = (n < s[g].size()) ? s[g][n] : '0;
        chk($sformatf("ir=%h mw=%0d cyc%0d", instr, 2 * g, n), 64'(obs[g]), 64'(e));
        if (obs[g].done) done_at[g] = n;
      end
      if (n < 16) snap[n] = obs[0];
      if (obs[0].illegal) ill_seen = 1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [15:0] t3_out, t4_out, t5_in;
    logic [4:0]  t4_op;
    int          lat;
    bit          ill;
  } vec_t;

  initial begin
    vec_t   vt [8];
    sched_t s [2];
    ctl_t   e;
    int     per;
    bit     drained;
    logic [31:0] r;
    logic [4:0]  legal_ops [13];

    legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd15, 5'd16, 5'd17, 5'd18};
    //          ir            t3_out    t4_out    t5_in     op     lat ill
    vt[0] = '{32'h28918000, 16'h0004, 16'h0008, 16'h0002, 5'd5,  7, 0};  // AND r1,r2,r3
    vt[1] = '{32'h78918000, 16'h0004, 16'h0008, 16'h0000, 5'd15, 8, 0};  // MUL r2,r3
    vt[2] = '{32'h88900000, 16'h0004, 16'h0004, 16'h0002, 5'd17, 7, 0};  // NEG r1,r2
    vt[3] = '{32'hF8918000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  5, 1};  // opcode 11111
    vt[4] = '{32'h1F838000, 16'h0001, 16'h0080, 16'h8000, 5'd3,  7, 0};  // ADD r15,r0,r7
    vt[5] = '{32'h812B0000, 16'h0020, 16'h0040, 16'h0000, 5'd16, 8, 0};  // DIV r5,r6
    vt[6] = '{32'h91A00000, 16'h0010, 16'h0010, 16'h0008, 5'd18, 7, 0};  // NOT r3,r4
    vt[7] = '{32'h00000000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  5, 1};  // opcode 00000

    // Reset state, held and after release.
    repeat (2) @(negedge clk);
    chk("reset d0", 64'(obs[0]), 64'd0);
    chk("reset d1", 64'(obs[1]), 64'd0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("idle d0", 64'(obs[0]), 64'd0);

    foreach (vt[i]) begin
      run_instr(vt[i].ir, -1);
      chk($sformatf("v%0d latency", i),      64'(done_at[0] + 1), 64'(vt[i].lat));
      chk($sformatf("v%0d latency mw2", i),  64'(done_at[1] + 1), 64'(vt[i].lat + 2));
      chk($sformatf("v%0d T3 out_sel", i),   64'(snap[3].rout),   64'(vt[i].t3_out));
      chk($sformatf("v%0d T4 out_sel", i),   64'(snap[4].rout),   64'(vt[i].t4_out));
      chk($sformatf("v%0d T4 operation", i), 64'(snap[4].op),     64'(vt[i].t4_op));
      chk($sformatf("v%0d T5 in_sel", i),    64'(snap[5].rin),    64'(vt[i].t5_in));
      chk($sformatf("v%0d illegal", i),      64'(ill_seen),       64'(vt[i].ill));
    end

    // start pulse during T2 is ignored.
    run_instr(32'h28918000, 2);
    chk("pulse T2 latency", 64'(done_at[0] + 1), 64'd7);

    // Reset during T4: outputs clear at once, no done afterwards.
    @(negedge clk);
    ir    = 32'h28918000;
    start = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset T4 op", 64'(obs[0].op), 64'd5);
    #1 clr_n = 1'b0;
    #1;
    chk("async reset d0", 64'(obs[0]), 64'd0);
    chk("async reset d1", 64'(obs[1]), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk($sformatf("post-reset idle d0 c%0d", n), 64'(obs[0]), 64'd0);
      chk($sformatf("post-reset idle d1 c%0d", n), 64'(obs[1]), 64'd0);
    end
    run_instr(32'h28918000, -1);
    chk("after reset latency", 64'(done_at[0] + 1), 64'd7);

    // start held high: back-to-back with exactly one Idle cycle between.
    s[0] = build(32'h78918000, 0);
    s[1] = build(32'h78918000, 2);
    @(negedge clk);
    ir    = 32'h78918000;
    start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        per = s[g].size() + 1;
        e = ((n % per) < s[g].size()) ? s[g][n % per] : '0;
        chk($sformatf("held start mw=%0d cyc%0d", 2 * g, n), 64'(obs[g]), 64'(e));
      end
    end
    start   = 1'b0;
    drained = 0;
    for (int n = 0; n < 20 && !drained; n++) begin
      @(negedge clk);
      drained = !obs[0].busy && !obs[1].busy;
    end
    chk("drain after held start", 64'(drained), 64'd1);

    // Randomised instructions, mostly legal opcodes, some stray start pulses.
    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[31:27] = legal_ops[$urandom_range(0, 12)];
      run_instr(r, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Hardware control sequencer that replaces the hand-timed control-signal FSM currently used to run a single register-register ALU instruction through the datapath.
- Steps fetch (T0–T2) and execute (T3–T5/T6) for every R-format ALU opcode, including two-word MUL/DIV results written to HI/LO.
- Generalised over register count and memory wait states; decodes register fields from the IR.
- Sits beside the datapath and drives its bus-select and load-enable inputs directly.

Parameters:
- NUM_REGS, 16, number of general registers; register field width RW = $clog2(NUM_REGS).
- MEM_WAIT, 0, extra cycles the memory read in T1 is held (0..15).
- OPW, 5, opcode field width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  begin one instruction; sampled only in IDLE.
- ir  in  32  IR contents from the datapath; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15] (register fields are the low RW bits of each 4-bit field).
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath controls.
- ZHIin, ZLOin, Zlowout, ZHighout, HIin, LOin  out  1 each  Z/HI/LO controls.
- reg_out_sel  out  NUM_REGS  one-hot register bus drive.
- reg_in_sel  out  NUM_REGS  one-hot register load.
- operation  out  OPW  ALU operation code.
- busy  out  1  high from T0 through DONE inclusive.
- done  out  1  one-cycle pulse at end of instruction.
- illegal  out  1  one-cycle pulse with done when the opcode is unsupported.

Behaviour:
- Reset (clr=0, async): state=IDLE; every output 0.
- All outputs are registered Moore decodes of the state register and change only on rising clk.
- States and asserted controls (all others 0):
  - IDLE: nothing asserted. start=1 → T0 on the next edge. start=0 → stay in IDLE.
  - T0: PCout, MARin, IncPC, ZHIin, ZLOin.
  - T1: Zlowout, PCin (first T1 cycle only), Read, MDRin. Held 1+MEM_WAIT cycles by a wait counter, then → T2.
  - T2: MDRout, IRin. The IR is valid from the next cycle on.
  - T3: latch opcode/ra/rb/rc from ir into internal registers. Decode outputs use the latched copies from T4 onward. Also in T3: reg_out_sel[rb], Yin.
  - T4: reg_out_sel[rc] (binary ops) or reg_out_sel[rb] (unary NEG/NOT); operation=latched opcode; ZHIin, ZLOin.
  - T5, non-MUL/DIV ops: Zlowout, reg_in_sel[ra]; → DONE.
  - T5, MUL/DIV: Zlowout, LOin; → T6.
  - T6: ZHighout, HIin; → DONE.
  - DONE: done=1; → IDLE.
- Unsupported opcode (decided at T3): T3 asserts no controls; go directly to DONE with illegal=1. No register, Z, HI or LO write occurs.
- operation is 0 in every state except T4.
- Latency with start accepted at edge k: T0 in cycle k+1. done is in cycle k+7 for ALU ops, k+8 for MUL/DIV, plus MEM_WAIT in both cases.
- start while busy: ignored; no queueing.
- start held high continuously: back-to-back instructions with exactly one IDLE cycle between them.
- Register field index ≥ NUM_REGS: only reachable when NUM_REGS<16. The index is truncated to RW bits. One-hot outputs never have more than one bit set.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The partially executed instruction is abandoned; no done pulse.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum;
  - opcode constants ADD=00011, SUB=00100, AND=00101, OR=00110, ROR=00111, ROL=01000, SHR=01001, SHRA=01010, SHL=01011, MUL=01111, DIV=10000, NEG=10001, NOT=10010;
  - helper functions is_unary, is_two_word and is_legal.
- One sub-module: reg_select_decoder (RW-bit index + enable → NUM_REGS one-hot), instantiated twice, for reg_out_sel and reg_in_sel.

Test Plan:
- AND instruction:
  - Stimulus: reset, then start with ir=0x28918000 (AND r1,r2,r3), MEM_WAIT=0.
  - Required: T0..T5 in 6 consecutive cycles; reg_out_sel=0x0004 in T3; 0x0008 with operation=00101 in T4; reg_in_sel=0x0002 in T5; done one cycle later.
- MUL with wait states:
  - Stimulus: ir=0x78918000 (MUL), MEM_WAIT=2.
  - Required: Read high 3 cycles; T5 asserts LOin with no reg_in_sel; T6 asserts ZHighout+HIin; done at k+10.
- NEG:
  - Stimulus: ir=0x88900000 (NEG r1,r2).
  - Required: reg_out_sel=0x0004 in both T3 and T4.
- Illegal opcode:
  - Stimulus: opcode 11111.
  - Required: done and illegal pulse together; no reg_in_sel, ZHIin/ZLOin, HIin or LOin after T2.
- Reset during T4:
  - Stimulus: drop clr during T4.
  - Required: all outputs 0 asynchronously; state IDLE; no done pulse; next start runs normally.
- start handling:
  - Stimulus: pulse start during T2; separately, hold start high.
  - Required: the T2 pulse is ignored; with start held, instructions run back-to-back with one IDLE cycle between done and the next T0.
